// File: rtl/stimulus_generator.sv
// stimulus_generator: valid/ready stimulus source with an in-order
// expectation scoreboard that timestamps issue and retires responses.
module stimulus_generator #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 16,
  parameter logic [DATA_W-1:0] EXP_XOR   = '0,
  parameter logic [31:0]       LFSR_SEED = 32'hACE12345
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       txn_count,
  input  logic [1:0]        mode,
  input  logic [7:0]        gap,
  output logic              stim_valid,
  output logic [DATA_W-1:0] stim_data,
  input  logic              stim_ready,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_data,
  output logic              result_valid,
  output logic [DATA_W-1:0] dut_response,
  output logic [DATA_W-1:0] expected_data,
  output logic [31:0]       latency,
  output logic              busy,
  output logic              done,
  output logic              orphan_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [DATA_W-1:0] POLY = DATA_W'(32'h8020_0003);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  logic [15:0]       remaining;
  logic [7:0]        gap_q;
  logic [7:0]        gap_cnt;
  logic [1:0]        mode_q;
  logic [31:0]       ts;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [31:0]       mem_t [DEPTH];

  logic push;
  logic pop;
  logic orphan;
  logic can_raise;

  function automatic logic [DATA_W-1:0] first_word(
    input logic [1:0] m
  );
    unique case (m)
      2'd1:    first_word = DATA_W'(LFSR_SEED);
      2'd2:    first_word = DATA_W'(1);
      default: first_word = '0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] next_word(
    input logic [1:0]        m,
    input logic [DATA_W-1:0] d
  );
    unique case (m)
      2'd1:    next_word = d[0] ? ((d >> 1) ^ POLY) : (d >> 1);
      2'd2:    next_word = {d[DATA_W-2:0], d[DATA_W-1]};
      default: next_word = d + DATA_W'(1);
    endcase
  endfunction

  assign push   = stim_valid & stim_ready;
  assign pop    = resp_valid & (count != '0);
  assign orphan = resp_valid & (count == '0);

  // occupancy after this cycle; a same-cycle push cannot feed a pop
  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: ;
    endcase
  end

  assign can_raise = count_next < FULL;

  // free-running issue/response timestamp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts <= '0;
    else        ts <= ts + 32'd1;
  end

  // scoreboard pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
    end
  end

  // scoreboard storage: expected word and issue time
  always_ff @(posedge clk) begin
    if (push) begin
      mem_d[wr_ptr] <= stim_data ^ EXP_XOR;
      mem_t[wr_ptr] <= ts;
    end
  end

  // retire responses against the oldest outstanding entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_valid  <= 1'b0;
      dut_response  <= '0;
      expected_data <= '0;
      latency       <= '0;
      orphan_err    <= 1'b0;
    end else begin
      result_valid <= pop;
      if (pop) begin
        dut_response  <= resp_data;
        expected_data <= mem_d[rd_ptr];
        latency       <= ts - mem_t[rd_ptr];
      end
      if (orphan) orphan_err <= 1'b1;
    end
  end

  // run sequencing and stimulus issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      remaining  <= '0;
      gap_q      <= '0;
      gap_cnt    <= '0;
      mode_q     <= '0;
      stim_valid <= 1'b0;
      stim_data  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            mode_q    <= mode;
            gap_q     <= gap;
            remaining <= txn_count;
            stim_data <= first_word(mode);
            if (txn_count == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state      <= S_ISSUE;
              busy       <= 1'b1;
              done       <= 1'b0;
              stim_valid <= can_raise;
            end
          end
        end
        S_ISSUE: begin
          if (push) begin
            remaining <= remaining - 16'd1;
            stim_data <= next_word(mode_q, stim_data);
            if (remaining == 16'd1) begin
              state      <= S_DRAIN;
              stim_valid <= 1'b0;
            end else if (gap_q != '0) begin
              state      <= S_GAP;
              gap_cnt    <= gap_q;
              stim_valid <= 1'b0;
            end else begin
              stim_valid <= can_raise;
            end
          end else if (!stim_valid) begin
            stim_valid <= can_raise;
          end
        end
        S_GAP: begin
          if (gap_cnt == 8'd1) begin
            state      <= S_ISSUE;
            stim_valid <= can_raise;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        S_DRAIN: begin
          if (count == '0) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
